// File: rtl/ssp_txfifo_wm_if.sv
// SSP TX FIFO bus: APB push side, serialiser request, control and status.
// The master drives the FIFO inputs, the slave is the FIFO itself.
interface ssp_txfifo_wm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  i_PSEL;
  logic                  i_PWRITE;
  logic [DATA_WIDTH-1:0] i_PWDATA;
  logic                  i_REQ;
  logic                  i_FLUSH;
  logic [ADDR_WIDTH:0]   i_WMARK;
  logic                  i_INTR_EN;
  logic                  i_FLAG_CLR;
  logic [DATA_WIDTH-1:0] o_TXDATA;
  logic                  o_TX_VALID;
  logic [ADDR_WIDTH:0]   o_LEVEL;
  logic                  o_FULL;
  logic                  o_EMPTY;
  logic                  o_SSPTXINTR;
  logic                  o_OVERFLOW;
  logic                  o_UNDERFLOW;

  modport master (
    output i_PSEL, i_PWRITE, i_PWDATA, i_REQ, i_FLUSH, i_WMARK, i_INTR_EN, i_FLAG_CLR,
    input  o_TXDATA, o_TX_VALID, o_LEVEL, o_FULL, o_EMPTY, o_SSPTXINTR, o_OVERFLOW, o_UNDERFLOW
  );

  modport slave (
    input  i_PSEL, i_PWRITE, i_PWDATA, i_REQ, i_FLUSH, i_WMARK, i_INTR_EN, i_FLAG_CLR,
    output o_TXDATA, o_TX_VALID, o_LEVEL, o_FULL, o_EMPTY, o_SSPTXINTR, o_OVERFLOW, o_UNDERFLOW
  );
endinterface

// File: rtl/ssp_txfifo_wm.sv
// SSP transmit FIFO: APB pushes, synchronised serialiser REQ edges pop (2 edges after the rise),
// first-word fall-through; a push while full is dropped and flagged, never stalled.
module ssp_txfifo_wm #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                i_PCLK,
  input  logic                i_CLEAR_B,
  ssp_txfifo_wm_if.slave      bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [LVL_W-1:0]      level_nxt;
  logic                  sync1;
  logic                  sync2;
  logic                  tx_valid;
  logic                  ovf_flag;
  logic                  unf_flag;

  logic push_req;
  logic pop_req;
  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;

  assign push_req = bus.i_PSEL & bus.i_PWRITE;
  assign pop_req  = sync1 & ~sync2;
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  // Space is judged on the registered level, so a same-cycle pop never makes room when full.
  assign push_ok  = push_req & ~full & ~bus.i_FLUSH;
  assign pop_ok   = pop_req & ~empty & ~bus.i_FLUSH;

  always_comb begin
    level_nxt = level;
    if (bus.i_FLUSH) begin
      level_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.i_REQ;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tx_valid <= 1'b0;
    end else begin
      level    <= level_nxt;
      tx_valid <= (level_nxt != '0);
      if (bus.i_FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // Set beats clear when both happen on the same edge.
  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      if (push_req && full && !bus.i_FLUSH) ovf_flag <= 1'b1;
      else if (bus.i_FLAG_CLR)              ovf_flag <= 1'b0;
      if (pop_req && empty && !bus.i_FLUSH) unf_flag <= 1'b1;
      else if (bus.i_FLAG_CLR)              unf_flag <= 1'b0;
    end
  end

  // Storage is deliberately left unreset; the head word is only meaningful while valid.
  always_ff @(posedge i_PCLK) begin
    if (push_ok) mem[wr_ptr] <= bus.i_PWDATA;
  end

  assign bus.o_TXDATA    = mem[rd_ptr];
  assign bus.o_TX_VALID  = tx_valid;
  assign bus.o_LEVEL     = level;
  assign bus.o_FULL      = full;
  assign bus.o_EMPTY     = empty;
  assign bus.o_SSPTXINTR = bus.i_INTR_EN & (level <= bus.i_WMARK);
  assign bus.o_OVERFLOW  = ovf_flag;
  assign bus.o_UNDERFLOW = unf_flag;
endmodule

// File: tb/tb_ssp_txfifo_wm.sv
// Bench for ssp_txfifo_wm: directed scenarios then random traffic, all checked every cycle
// against a queue-based model of the FIFO.
module tb_ssp_txfifo_wm;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic pclk;
  logic clear_b;

  ssp_txfifo_wm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ssp_txfifo_wm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_PCLK    (pclk),
    .i_CLEAR_B (clear_b),
    .bus       (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the FIFO as a queue, plus the edge number at which a seen REQ rise takes effect.
  logic [DW-1:0] q[$];
  logic m_ovf, m_unf, m_last_req;
  int   m_pend, m_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_last_req = 1'b0; m_pend = -1; m_cyc = 0;
  endtask

  task automatic model_edge();
    bit pop_r, push_r, was_full, was_empty, set_o, set_u;
    pop_r  = (m_pend == m_cyc);
    if (bus.i_REQ && !m_last_req) m_pend = m_cyc + 1;
    m_last_req = bus.i_REQ;
    push_r = bus.i_PSEL && bus.i_PWRITE;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    set_o = 1'b0; set_u = 1'b0;
    if (bus.i_FLUSH) begin
      q.delete();
    end else begin
      set_o = push_r && was_full;
      set_u = pop_r && was_empty;
      if (pop_r && !was_empty) void'(q.pop_front());
      if (push_r && !was_full) q.push_back(bus.i_PWDATA);
    end
    if (set_o) m_ovf = 1'b1; else if (bus.i_FLAG_CLR) m_ovf = 1'b0;
    if (set_u) m_unf = 1'b1; else if (bus.i_FLAG_CLR) m_unf = 1'b0;
    m_cyc++;
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    check({ph, ":level"}, 32'(bus.o_LEVEL),     32'(n));
    check({ph, ":full"},  32'(bus.o_FULL),      (n == DEPTH) ? 32'd1 : 32'd0);
    check({ph, ":empty"}, 32'(bus.o_EMPTY),     (n == 0) ? 32'd1 : 32'd0);
    check({ph, ":valid"}, 32'(bus.o_TX_VALID),  (n != 0) ? 32'd1 : 32'd0);
    check({ph, ":intr"},  32'(bus.o_SSPTXINTR),
          (bus.i_INTR_EN && (n <= int'(bus.i_WMARK))) ? 32'd1 : 32'd0);
    check({ph, ":ovf"},   32'(bus.o_OVERFLOW),  32'(m_ovf));
    check({ph, ":unf"},   32'(bus.o_UNDERFLOW), 32'(m_unf));
    if (n != 0) check({ph, ":txdata"}, 32'(bus.o_TXDATA), 32'(q[0]));
  endtask

  task automatic tick(input string ph);
    @(posedge pclk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    #3;
    clear_b = 1'b0;
    #1;
    model_reset();
    check_all({ph, ":async"});
    @(posedge pclk);
    #1;
    clear_b = 1'b1;
    check_all({ph, ":rel"});
  endtask

  task automatic push(input logic [DW-1:0] d, input string ph);
    bus.i_PSEL = 1'b1; bus.i_PWRITE = 1'b1; bus.i_PWDATA = d;
    tick(ph);
    bus.i_PSEL = 1'b0; bus.i_PWRITE = 1'b0;
  endtask

  task automatic req_pulse(input string ph);
    bus.i_REQ = 1'b1;
    tick(ph);
    tick(ph);
    bus.i_REQ = 1'b0;
    tick(ph);
  endtask

  initial begin
    clear_b = 1'b0;
    bus.i_PSEL = 1'b0; bus.i_PWRITE = 1'b0; bus.i_PWDATA = '0; bus.i_REQ = 1'b0;
    bus.i_FLUSH = 1'b0; bus.i_WMARK = '0; bus.i_INTR_EN = 1'b1; bus.i_FLAG_CLR = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge pclk);
    #1;
    clear_b = 1'b1;

    // Fill with 0x11..0x88, then overflow with 0x99.
    for (int i = 1; i <= DEPTH; i++) push(DW'(8'h11 * i), "fill");
    check("fill:head", 32'(bus.o_TXDATA), 32'h11);
    check("fill:full", 32'(bus.o_FULL), 32'd1);
    push(8'h99, "ovf");
    check("ovf:flag", 32'(bus.o_OVERFLOW), 32'd1);
    for (int i = 0; i < DEPTH; i++) req_pulse("drain");
    check("drain:empty", 32'(bus.o_EMPTY), 32'd1);
    req_pulse("unf");
    check("unf:flag", 32'(bus.o_UNDERFLOW), 32'd1);
    bus.i_FLAG_CLR = 1'b1; tick("fclr"); bus.i_FLAG_CLR = 1'b0;

    // Level 3, REQ held high for 10 cycles gives exactly one pop.
    for (int i = 0; i < 3; i++) push(DW'($urandom), "hold_fill");
    bus.i_REQ = 1'b1;
    for (int i = 0; i < 10; i++) tick("hold");
    bus.i_REQ = 1'b0;
    tick("hold");
    check("hold:level", 32'(bus.o_LEVEL), 32'd2);

    // Level 4, 12 simultaneous push/pop pairs wrap the pointers.
    for (int i = 0; i < 2; i++) push(DW'($urandom), "pp_fill");
    for (int i = 0; i < 12; i++) begin
      bus.i_REQ = 1'b1; tick("pp");
      bus.i_REQ = 1'b0;
      bus.i_PSEL = 1'b1; bus.i_PWRITE = 1'b1; bus.i_PWDATA = DW'($urandom);
      tick("pp");
      bus.i_PSEL = 1'b0; bus.i_PWRITE = 1'b0;
      tick("pp");
    end
    check("pp:level", 32'(bus.o_LEVEL), 32'd4);

    // Watermark 2: fill to 5, drain, then repeat with the interrupt disabled.
    bus.i_FLUSH = 1'b1; tick("wm_flush"); bus.i_FLUSH = 1'b0;
    bus.i_WMARK = 4'd2;
    for (int en = 1; en >= 0; en--) begin
      bus.i_INTR_EN = en[0];
      for (int i = 0; i < 5; i++) push(DW'($urandom), "wm_fill");
      check("wm:intr_hi_lvl", 32'(bus.o_SSPTXINTR), 32'd0);
      for (int i = 0; i < 5; i++) req_pulse("wm_drain");
    end
    bus.i_INTR_EN = 1'b1;

    // Overflow set, level 6, flush with a simultaneous push.
    for (int i = 0; i < DEPTH; i++) push(DW'($urandom), "fl_fill");
    push(8'hEE, "fl_ovf");
    req_pulse("fl_pop"); req_pulse("fl_pop");
    bus.i_FLUSH = 1'b1; bus.i_PSEL = 1'b1; bus.i_PWRITE = 1'b1; bus.i_PWDATA = 8'h5A;
    tick("flush");
    bus.i_FLUSH = 1'b0; bus.i_PSEL = 1'b0; bus.i_PWRITE = 1'b0;
    check("flush:ovf_kept", 32'(bus.o_OVERFLOW), 32'd1);
    check("flush:empty", 32'(bus.o_EMPTY), 32'd1);

    // Async reset between edges with data and a pending REQ edge.
    for (int i = 0; i < 3; i++) push(DW'($urandom), "rst_fill");
    bus.i_REQ = 1'b1; tick("rst_req");
    bus.i_REQ = 1'b0;
    do_reset("midrst");
    tick("midrst_after");

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.i_PSEL     = ($urandom_range(0, 1) == 1);
      bus.i_PWRITE   = ($urandom_range(0, 3) != 0);
      bus.i_PWDATA   = DW'($urandom);
      if ($urandom_range(0, 2) == 0) bus.i_REQ = ~bus.i_REQ;
      bus.i_FLUSH    = ($urandom_range(0, 40) == 0);
      bus.i_FLAG_CLR = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 30) == 0) bus.i_WMARK = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 30) == 0) bus.i_INTR_EN = ~bus.i_INTR_EN;
      if ($urandom_range(0, 300) == 0) do_reset("rnd_rst");
      else tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ssp_txfifo_wm.md
Name: ssp_txfifo_wm

Overview:
Parametrised transmit FIFO for the SSP transmit path. It is the next generation of the fixed 4x8 handshake TX FIFO and buffers APB write data for the serialiser.
- Pops one word per rising edge of the serialiser request, after a 2-flop synchroniser.
- Adds a programmable low-watermark interrupt, occupancy output, synchronous flush, and sticky overflow/underflow flags.

Parameters:
DATA_WIDTH, 8, width of each FIFO word and of i_PWDATA/o_TXDATA
ADDR_WIDTH, 3, pointer width; FIFO depth = 2**ADDR_WIDTH (8)

Ports:
i_PCLK  input  1  system clock, all state on rising edge
i_CLEAR_B  input  1  reset, asynchronous, active-low
i_PSEL  input  1  APB select
i_PWRITE  input  1  APB write strobe; push request = i_PSEL & i_PWRITE
i_PWDATA  input  DATA_WIDTH  data to push
i_REQ  input  1  serialiser data request, asynchronous; its rising edge requests a pop
i_FLUSH  input  1  synchronous FIFO clear
i_WMARK  input  ADDR_WIDTH+1  low watermark level
i_INTR_EN  input  1  TX interrupt enable
i_FLAG_CLR  input  1  clears the sticky overflow/underflow flags
o_TXDATA  output  DATA_WIDTH  head-of-FIFO word (first-word fall-through)
o_TX_VALID  output  1  FIFO non-empty, driven from a flop
o_LEVEL  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
o_FULL  output  1  level == DEPTH
o_EMPTY  output  1  level == 0
o_SSPTXINTR  output  1  i_INTR_EN & (o_LEVEL <= i_WMARK)
o_OVERFLOW  output  1  sticky: push attempted while full
o_UNDERFLOW  output  1  sticky: pop request while empty

Behaviour:
- Reset (i_CLEAR_B low, asynchronous):
  - wr_ptr, rd_ptr, level, both synchroniser flops, o_TX_VALID, o_OVERFLOW and o_UNDERFLOW go to 0.
  - o_EMPTY=1, o_FULL=0, o_LEVEL=0.
  - o_SSPTXINTR = i_INTR_EN (level 0 <= any i_WMARK).
  - Memory contents are not reset. o_TXDATA is don't-care while empty.
- Pop request:
  - i_REQ passes through sync1 then sync2; pop_req = sync1 & ~sync2.
  - If i_REQ rises before edge k, sync1=1 after edge k and the pop executes at edge k+1.
  - One pop per rising edge, however long i_REQ stays high.
- Push: push_req = i_PSEL & i_PWRITE, sampled each edge.
  - Accepted only when level < DEPTH.
  - A pop in the same cycle does not free space for a write while full.
- Accepted push: mem[wr_ptr] <= i_PWDATA; wr_ptr increments modulo DEPTH (natural wrap).
- Accepted pop (level > 0): rd_ptr increments modulo DEPTH. o_TXDATA = mem[rd_ptr] combinationally, so the next word appears in the same cycle the pointer advances.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both accepted: unchanged.
  - neither: unchanged.
  - Level never exceeds DEPTH and never goes below 0.
- o_TX_VALID is registered with D = (next level != 0), so it equals ~o_EMPTY every cycle with no extra latency.
- Overflow: push_req while full, not flushing -> o_OVERFLOW set at that edge. The data is dropped and the pointers do not move.
- Underflow: pop_req while empty, not flushing -> o_UNDERFLOW set. Pointers do not move.
- Flag clear: i_FLAG_CLR clears both flags at the edge. If a new set condition occurs in the same cycle, set wins.
- Flush: i_FLUSH=1 at an edge sets wr_ptr=rd_ptr=level=0.
  - Flush has priority over a push and a pop in the same cycle; both are discarded and no flags are set.
  - Flush does not clear the sticky flags or the synchroniser flops.
- Interrupt: o_SSPTXINTR is combinational from the registered level, i_WMARK and i_INTR_EN.
  - i_WMARK >= DEPTH gives a permanently asserted interrupt while enabled.
  - i_WMARK = 0 asserts only when empty.
- Reset mid-operation: all state clears immediately without waiting for a clock edge. Any pending synchronised REQ edge is lost.

Test Plan:
- Reset, then 8 pushes of 0x11..0x88 with no REQ -> o_LEVEL 1..8, o_FULL=1 after 8th edge, o_TX_VALID=1, o_TXDATA=0x11.
- Full FIFO, push 0x99 -> o_OVERFLOW=1, o_LEVEL=8. Then 8 REQ pulses -> data popped 0x11..0x88 in order, 0x99 never seen, o_EMPTY=1. A 9th REQ pulse -> o_UNDERFLOW=1.
- REQ held high 10 cycles with level=3 -> exactly one pop, at the 2nd edge after the rise; o_LEVEL 3->2.
- Level=4 with a push and a synchronised pop in the same cycle -> o_LEVEL stays 4. Across 12 push/pop pairs the pointers wrap, and o_TXDATA matches the write order throughout.
- i_WMARK=2, i_INTR_EN=1; fill to 5, then pop -> o_SSPTXINTR rises on the edge where o_LEVEL becomes 2. With i_INTR_EN=0 it stays 0.
- Level=6 with i_FLUSH and a push on the same edge -> o_LEVEL=0, o_EMPTY=1, o_TX_VALID=0, flags unchanged. Asserting i_CLEAR_B low between edges clears o_LEVEL and the flags immediately.
